// File: rtl/calc_key_sequencer.sv
// Keypad sequencer for the calculator: loads operands/operator, launches the ALU, flags the result.
// Optional build macro CALC_CHAIN_EN: an operator key after a result reuses alu_result as operand A.
module calc_key_sequencer #(
    parameter int EXEC_CYCLES = 3,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic [3:0] alu_result,
    output logic       a_en,
    output logic       b_en,
    output logic       op_en,
    output logic [3:0] reg_d,
    output logic [1:0] op_d,
    output logic       alu_start,
    output logic       result_valid,
    output logic       err,
    output logic [2:0] state_o
);

    localparam logic [2:0] S_A    = 3'd0;
    localparam logic [2:0] S_OP   = 3'd1;
    localparam logic [2:0] S_B    = 3'd2;
    localparam logic [2:0] S_EQ   = 3'd3;
    localparam logic [2:0] S_EXEC = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             is_digit;
    logic             is_op;
    logic             is_eq;
    logic             is_clr;
    logic [1:0]       op_code;

    assign is_digit = key_valid && (key_code <= 4'd9);
    assign is_op    = key_valid && (key_code >= 4'd10) && (key_code <= 4'd13);
    assign is_eq    = key_valid && (key_code == 4'd14);
    assign is_clr   = key_valid && (key_code == 4'd15);
    // Operator keys 10..13 map to 0..3; the low two bits plus 2 give key_code-10 modulo 4.
    assign op_code  = key_code[1:0] + 2'd2;
    assign state_o  = state;

`ifndef CALC_CHAIN_EN
    logic unused_alu;
    assign unused_alu = ^alu_result;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_A;
            cnt          <= '0;
            a_en         <= 1'b0;
            b_en         <= 1'b0;
            op_en        <= 1'b0;
            alu_start    <= 1'b0;
            err          <= 1'b0;
            result_valid <= 1'b0;
            reg_d        <= 4'd0;
            op_d         <= 2'd0;
        end else begin
            a_en      <= 1'b0;
            b_en      <= 1'b0;
            op_en     <= 1'b0;
            alu_start <= 1'b0;
            err       <= 1'b0;
            if (is_clr) begin
                a_en         <= 1'b1;
                b_en         <= 1'b1;
                op_en        <= 1'b1;
                reg_d        <= 4'd0;
                op_d         <= 2'd0;
                result_valid <= 1'b0;
                cnt          <= '0;
                state        <= S_A;
            end else begin
                case (state)
                    S_A: begin
                        if (is_digit) begin
                            a_en  <= 1'b1;
                            reg_d <= key_code;
                            state <= S_OP;
                        end else if (is_op || is_eq) begin
                            err <= 1'b1;
                        end
                    end
                    S_OP: begin
                        if (is_op) begin
                            op_en <= 1'b1;
                            op_d  <= op_code;
                            state <= S_B;
                        end else if (is_digit) begin
                            a_en  <= 1'b1;
                            reg_d <= key_code;
                        end else if (is_eq) begin
                            err <= 1'b1;
                        end
                    end
                    S_B: begin
                        if (is_digit) begin
                            b_en  <= 1'b1;
                            reg_d <= key_code;
                            state <= S_EQ;
                        end else if (is_op) begin
                            op_en <= 1'b1;
                            op_d  <= op_code;
                        end else if (is_eq) begin
                            err <= 1'b1;
                        end
                    end
                    S_EQ: begin
                        if (is_eq) begin
                            alu_start <= 1'b1;
                            cnt       <= CNT_W'(EXEC_CYCLES - 1);
                            state     <= S_EXEC;
                        end else if (is_digit) begin
                            b_en  <= 1'b1;
                            reg_d <= key_code;
                        end else if (is_op) begin
                            err <= 1'b1;
                        end
                    end
                    S_EXEC: begin
                        // Non-clear keys are deliberately dropped while the ALU is busy.
                        if (cnt == '0) begin
                            result_valid <= 1'b1;
                            state        <= S_DONE;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    S_DONE: begin
                        if (is_digit) begin
                            result_valid <= 1'b0;
                            a_en         <= 1'b1;
                            reg_d        <= key_code;
                            state        <= S_OP;
                        end else if (is_op) begin
`ifdef CALC_CHAIN_EN
                            result_valid <= 1'b0;
                            a_en         <= 1'b1;
                            reg_d        <= alu_result;
                            op_en        <= 1'b1;
                            op_d         <= op_code;
                            state        <= S_B;
`else
                            err <= 1'b1;
`endif
                        end
                    end
                    default: begin
                        state <= S_A;
                    end
                endcase
            end
        end
    end

endmodule
